rf_commit_sequencer: RTL and testbench

- Sits between the ROB commit stage and the register file's single write port (set idx/value/recorder plus clear).
- Accepts up to two committed register writes per cycle (lane 0 older than lane 1) into a small in-order FIFO and drains one write per cycle to the register file.
- Sequences misprediction flushes: drains every committed write first, then issues a one-cycle register-file clear, so no committed result is lost to the clear.

---
 rtl/rf_commit_sequencer.sv | 147 ++++++++++++++
 tb/tb_rf_commit_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_commit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rf_commit_sequencer
// Purpose  : Funnels up to two committed register writes per cycle into a
//            small in-order FIFO and drains one write per cycle into the
//            register file. On a misprediction flush it drains all committed
//            writes first, then issues a one-cycle register-file clear.
// Revision : 1.0  initial release
// ============================================================================

`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module rf_commit_sequencer #(
    parameter int DEPTH = 4,
    parameter int REC_W = `ROB_SIZE_BIT
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       cm0_valid,
    input  logic [4:0]                 cm0_idx,
    input  logic [31:0]                cm0_val,
    input  logic [REC_W-1:0]           cm0_rec,
    input  logic                       cm1_valid,
    input  logic [4:0]                 cm1_idx,
    input  logic [31:0]                cm1_val,
    input  logic [REC_W-1:0]           cm1_rec,
    output logic                       cm_ready,
    input  logic                       flush_req,
    output logic                       flush_ack,
    output logic [4:0]                 rf_set_idx,
    output logic [31:0]                rf_set_val,
    output logic [REC_W-1:0]           rf_set_rec,
    output logic                       rf_clear,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [4:0]         r_mem_idx [DEPTH];
    logic [31:0]        r_mem_val [DEPTH];
    logic [REC_W-1:0]   r_mem_rec [DEPTH];

    logic               w_push0;
    logic               w_push1;
    logic               w_pop;
    logic [CNT_W-1:0]   w_free;
    logic [PTR_W-1:0]   w_wr_ptr1;
    logic [CNT_W-1:0]   w_npush;

    // Admission: two free slots guarantee a dual push never overflows, even
    // when no pop happens in the same cycle. Held low while in reset.
    always_comb begin
        w_free   = CNT_W'(DEPTH) - r_count;
        cm_ready = rst_in && rdy_in && (r_state == ST_IDLE) && (w_free >= CNT_W'(2));
        w_push0  = cm_ready && cm0_valid && (cm0_idx != 5'd0);
        w_push1  = cm_ready && cm1_valid && (cm1_idx != 5'd0);
        // Lane 1 lands right after lane 0 when both push, else at the tail.
        w_wr_ptr1 = w_push0 ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
        w_npush   = CNT_W'(w_push0) + CNT_W'(w_push1);
    end

    // Drain side: head entry is presented combinationally whenever a pop occurs.
    always_comb begin
        w_pop      = rdy_in && (r_count != '0) && (r_state != ST_CLEAR);
        rf_set_idx = 5'd0;
        rf_set_val = 32'd0;
        rf_set_rec = '0;
        if (w_pop) begin
            rf_set_idx = r_mem_idx[r_rd_ptr];
            rf_set_val = r_mem_val[r_rd_ptr];
            rf_set_rec = r_mem_rec[r_rd_ptr];
        end
    end

    // Flush sequencing: IDLE -> DRAIN on request, DRAIN -> CLEAR once empty,
    // CLEAR lasts a single cycle. Nothing advances while rdy_in is low.
    always_comb begin
        w_state_nxt = r_state;
        if (rdy_in) begin
            case (r_state)
                ST_IDLE:  if (flush_req)        w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (r_count == '0)    w_state_nxt = ST_CLEAR;
                ST_CLEAR:                       w_state_nxt = ST_IDLE;
                default:                        w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Clear and acknowledge share the single CLEAR cycle.
    always_comb begin
        rf_clear  = rdy_in && (r_state == ST_CLEAR);
        flush_ack = rdy_in && (r_state == ST_CLEAR);
        busy      = (r_state != ST_IDLE) || (r_count != '0);
        count     = r_count;
    end

    // Control state: FSM, FIFO pointers and occupancy.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= ST_IDLE;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count  <= r_count + w_npush - CNT_W'(w_pop);
        end
    end

    // FIFO storage; contents are only observed once count says they are valid.
    always_ff @(posedge clk_in) begin
        if (w_push0) begin
            r_mem_idx[r_wr_ptr] <= cm0_idx;
            r_mem_val[r_wr_ptr] <= cm0_val;
            r_mem_rec[r_wr_ptr] <= cm0_rec;
        end
        if (w_push1) begin
            r_mem_idx[w_wr_ptr1] <= cm1_idx;
            r_mem_val[w_wr_ptr1] <= cm1_val;
            r_mem_rec[w_wr_ptr1] <= cm1_rec;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_commit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_commit_sequencer
// Purpose  : Directed, self-checking bench for rf_commit_sequencer
//            (DEPTH=4, REC_W=4). Inputs change 1 time unit after the rising
//            edge; outputs are compared on the falling edge.
// Revision : 1.0  initial release
// ============================================================================

module tb_rf_commit_sequencer;

    localparam int DEPTH = 4;
    localparam int REC_W = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              cm0_valid, cm1_valid;
    logic [4:0]        cm0_idx, cm1_idx;
    logic [31:0]       cm0_val, cm1_val;
    logic [REC_W-1:0]  cm0_rec, cm1_rec;
    logic              cm_ready;
    logic              flush_req;
    logic              flush_ack;
    logic [4:0]        rf_set_idx;
    logic [31:0]       rf_set_val;
    logic [REC_W-1:0]  rf_set_rec;
    logic              rf_clear;
    logic              busy;
    logic [2:0]        count;

    int n_tests = 0;
    int n_fail  = 0;

    rf_commit_sequencer #(.DEPTH(DEPTH), .REC_W(REC_W)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .cm0_valid  (cm0_valid),
        .cm0_idx    (cm0_idx),
        .cm0_val    (cm0_val),
        .cm0_rec    (cm0_rec),
        .cm1_valid  (cm1_valid),
        .cm1_idx    (cm1_idx),
        .cm1_val    (cm1_val),
        .cm1_rec    (cm1_rec),
        .cm_ready   (cm_ready),
        .flush_req  (flush_req),
        .flush_ack  (flush_ack),
        .rf_set_idx (rf_set_idx),
        .rf_set_val (rf_set_val),
        .rf_set_rec (rf_set_rec),
        .rf_clear   (rf_clear),
        .busy       (busy),
        .count      (count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dval(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : (32'hA000_0000 | {27'd0, idx});
    endfunction

    function automatic logic [REC_W-1:0] drec(input logic [4:0] idx);
        return idx[REC_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic exp_rdy, input logic [2:0] exp_cnt,
                           input logic [4:0] exp_idx, input logic [31:0] exp_val,
                           input logic [REC_W-1:0] exp_rec);
        chk({tag, "/cm_ready"}, {31'd0, cm_ready}, {31'd0, exp_rdy});
        chk({tag, "/count"},    {29'd0, count},    {29'd0, exp_cnt});
        chk({tag, "/idx"},      {27'd0, rf_set_idx}, {27'd0, exp_idx});
        chk({tag, "/val"},      rf_set_val,        exp_val);
        chk({tag, "/rec"},      {28'd0, rf_set_rec}, {28'd0, exp_rec});
    endtask

    // Drive one cycle of commits with derived payloads and check at the falling edge.
    task automatic cyc(input string tag, input logic v0, input logic [4:0] i0,
                       input logic v1, input logic [4:0] i1, input logic exp_rdy,
                       input logic [2:0] exp_cnt, input logic [4:0] exp_idx);
        cm0_valid = v0; cm0_idx = i0; cm0_val = dval(i0); cm0_rec = drec(i0);
        cm1_valid = v1; cm1_idx = i1; cm1_val = dval(i1); cm1_rec = drec(i1);
        @(negedge clk_in);
        chk_out(tag, exp_rdy, exp_cnt, exp_idx, dval(exp_idx), drec(exp_idx));
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_req = 1'b0;
        cm0_valid = 1'b0; cm0_idx = '0; cm0_val = '0; cm0_rec = '0;
        cm1_valid = 1'b0; cm1_idx = '0; cm1_val = '0; cm1_rec = '0;

        // Reset state
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk_out("reset", 1'b0, 3'd0, 5'd0, 32'd0, 4'd0);
        chk("reset/busy",  {31'd0, busy},      32'd0);
        chk("reset/clear", {31'd0, rf_clear},  32'd0);
        chk("reset/ack",   {31'd0, flush_ack}, 32'd0);
        tick();
        rst_in = 1'b1;

        // Dual commit, in-order drain
        cm0_valid = 1'b1; cm0_idx = 5'd5; cm0_val = 32'h11; cm0_rec = 4'd2;
        cm1_valid = 1'b1; cm1_idx = 5'd6; cm1_val = 32'h22; cm1_rec = 4'd3;
        @(negedge clk_in);
        chk_out("dual/a", 1'b1, 3'd0, 5'd0, 32'd0, 4'd0);
        tick();
        cm0_valid = 1'b0; cm1_valid = 1'b0;
        @(negedge clk_in);
        chk_out("dual/b", 1'b1, 3'd2, 5'd5, 32'h11, 4'd2);
        tick();
        @(negedge clk_in);
        chk_out("dual/c", 1'b1, 3'd1, 5'd6, 32'h22, 4'd3);
        tick();
        @(negedge clk_in);
        chk_out("dual/d", 1'b1, 3'd0, 5'd0, 32'd0, 4'd0);
        tick();

        // x0 on lane 0 dropped, lane-1-only commit takes one slot
        cyc("x0/a", 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 3'd0, 5'd0);  tick();
        cyc("x0/b", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd1, 5'd7);  tick();
        cyc("x0/c", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd0, 5'd0);  tick();

        // Back-to-back dual commits, backpressure and pointer wrap
        cyc("b2b/1", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 3'd0, 5'd0); tick();
        cyc("b2b/2", 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 3'd2, 5'd1); tick();
        cyc("b2b/3", 1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 3'd3, 5'd2); tick();
        cyc("b2b/4", 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 3'd2, 5'd3); tick();
        cyc("b2b/5", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd3, 5'd4); tick();
        cyc("b2b/6", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd2, 5'd5); tick();
        cyc("b2b/7", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd1, 5'd6); tick();
        cyc("b2b/8", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd0, 5'd0); tick();

        // Flush with three entries queued
        cyc("fl/1", 1'b1, 5'd8,  1'b1, 5'd9,  1'b1, 3'd0, 5'd0);  tick();
        cyc("fl/2", 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 3'd2, 5'd8);  tick();
        flush_req = 1'b1;
        cyc("fl/3", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd3, 5'd9);    tick();
        cyc("fl/4", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd2, 5'd10);
        chk("fl/4/busy", {31'd0, busy}, 32'd1);
        tick();
        cyc("fl/5", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1, 5'd11);   tick();
        cyc("fl/6", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 5'd0);
        chk("fl/6/clear", {31'd0, rf_clear}, 32'd0);
        tick();
        flush_req = 1'b0;
        cyc("fl/7", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 5'd0);
        chk("fl/7/clear", {31'd0, rf_clear},  32'd1);
        chk("fl/7/ack",   {31'd0, flush_ack}, 32'd1);
        chk("fl/7/busy",  {31'd0, busy},      32'd1);
        tick();
        cyc("fl/8", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd0, 5'd0);
        chk("fl/8/clear", {31'd0, rf_clear}, 32'd0);
        chk("fl/8/busy",  {31'd0, busy},     32'd0);
        tick();

        // Flush with same-cycle commit, then rdy_in stalls the drain
        flush_req = 1'b1;
        cyc("st/1", 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 3'd0, 5'd0);  tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("st/hold", 1'b1, 5'd14, 1'b1, 5'd15, 1'b0, 3'd2, 5'd0);
            chk("st/hold/busy",  {31'd0, busy},     32'd1);
            chk("st/hold/clear", {31'd0, rf_clear}, 32'd0);
            tick();
        end
        rdy_in = 1'b1; flush_req = 1'b0;
        cyc("st/5", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd2, 5'd12);   tick();
        cyc("st/6", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1, 5'd13);   tick();
        cyc("st/7", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 5'd0);
        chk("st/7/clear", {31'd0, rf_clear}, 32'd0);
        tick();
        cyc("st/8", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 5'd0);
        chk("st/8/clear", {31'd0, rf_clear},  32'd1);
        chk("st/8/ack",   {31'd0, flush_ack}, 32'd1);

        // Asynchronous reset while in CLEAR
        #1;
        rst_in = 1'b0;
        #1;
        chk("rst/clear", {31'd0, rf_clear},  32'd0);
        chk("rst/ack",   {31'd0, flush_ack}, 32'd0);
        chk("rst/count", {29'd0, count},     32'd0);
        chk("rst/busy",  {31'd0, busy},      32'd0);
        chk("rst/ready", {31'd0, cm_ready},  32'd0);
        tick();
        rst_in = 1'b1;
        cyc("rst/after", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd0, 5'd0);
        chk("rst/after/busy", {31'd0, busy}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
